// File: rtl/uart_prog_loader_pkg.sv
// Shared constants for the UART program loader: bus widths, default ROM
// depth, state encodings for the loader and the byte receiver, and a helper
// that drops one received byte into its lane of the word being assembled.
package loader_pkg;

    localparam int ADDR_W        = 14;
    localparam int WORD_W        = 32;
    localparam int LEN_W         = 16;
    localparam int MAX_WORDS_DEF = 16384;

    // Loader FSM encodings, kept as plain constants so older tools that
    // consume this slice can read them without enum support.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // Byte receiver encodings.
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Replace byte lane 'lane' of 'word' with 'data'; lane 0 is bits [7:0],
    // which is where the first little-endian byte of a word belongs.
    function automatic logic [WORD_W-1:0] merge_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic [7:0]        data
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[{lane, 3'b000} +: 8] = data;
        return result;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver. The line is synchronised into the clock domain,
// a falling edge starts a frame, the start bit is re-checked half a bit
// later to reject glitches, and each data bit is sampled once per bit
// period. The stop bit is judged at its middle, which also re-arms the
// receiver early enough to catch a back-to-back frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    import loader_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection;
    // everything resets to the idle-high line level so reset never looks
    // like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame state machine: bit timer, LSB-first shift register and the
    // one-cycle byte_valid / frame_err strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: receives a length-prefixed little-endian word stream over
// UART and writes it into the instruction ROM through the fetch stage's
// upgrade port. The loader holds the ROM (upg_done_o low) while loading and
// hands it back to the CPU when the image is complete or the load fails.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int MAX_WORDS    = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [WORD_W-1:0] upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [LEN_W:0] MAX_LIM = (LEN_W + 1)'(MAX_WORDS);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;

    logic [2:0]        state;
    logic              start_prev;
    logic              start_rise;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  word_cnt;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] word_asm;
    logic [WORD_W-1:0] word_next;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign start_rise = start & ~start_prev;
    assign len_next   = {byte_data, len[7:0]};
    assign word_next  = merge_byte(word_asm, byte_idx, byte_data);

    // Remember the previous start level; it resets high so a start input
    // that is already high when reset releases does not arm a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start;
        end
    end

    // Loader FSM: arms on a start edge, collects the word count, assembles
    // words byte by byte, issues one write strobe per word and finally
    // releases the ROM. Any framing error during a load releases the ROM
    // with err_o set and whatever partial image was already written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= 2'd0;
            word_asm   <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b1;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (start_rise) begin
                        state      <= ST_LEN_LO;
                        busy_o     <= 1'b1;
                        upg_done_o <= 1'b0;
                        err_o      <= 1'b0;
                        upg_adr_o  <= '0;
                        byte_idx   <= 2'd0;
                        word_cnt   <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (frame_err) begin
                        state      <= ST_ERR;
                        err_o      <= 1'b1;
                        upg_done_o <= 1'b1;
                        busy_o     <= 1'b0;
                    end else if (byte_valid) begin
                        len[7:0] <= byte_data;
                        state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (frame_err) begin
                        state      <= ST_ERR;
                        err_o      <= 1'b1;
                        upg_done_o <= 1'b1;
                        busy_o     <= 1'b0;
                    end else if (byte_valid) begin
                        len[15:8] <= byte_data;
                        if (len_next == '0) begin
                            state <= ST_DONE;
                        end else if ({1'b0, len_next} > MAX_LIM) begin
                            state      <= ST_ERR;
                            err_o      <= 1'b1;
                            upg_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (frame_err) begin
                        state      <= ST_ERR;
                        err_o      <= 1'b1;
                        upg_done_o <= 1'b1;
                        busy_o     <= 1'b0;
                    end else if (byte_valid) begin
                        word_asm <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state     <= ST_WRITE;
                            upg_wen_o <= 1'b1;
                            upg_dat_o <= word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    // The address only advances after the strobe cycle, so
                    // the ROM sees a stable address/data pair during it.
                    upg_adr_o <= upg_adr_o + 1'b1;
                    word_cnt  <= word_cnt + 1'b1;
                    if (word_cnt + 1'b1 == len) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    upg_done_o <= 1'b1;
                    busy_o     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. Stimulus drives the rx line bit
// by bit; expected ROM writes go into a queue that a separate monitor pops
// whenever the DUT strobes upg_wen_o.
module tb_uart_prog_loader;

    localparam int CPB = 4;

    typedef struct packed {
        logic [13:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic        upg_wen_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        busy_o;
    logic        err_o;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (16384)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .start     (start),
        .upg_wen_o (upg_wen_o),
        .upg_adr_o (upg_adr_o),
        .upg_dat_o (upg_dat_o),
        .upg_done_o(upg_done_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && upg_wen_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: got adr %h dat %h, expected no write",
                         upg_adr_o, upg_dat_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (upg_adr_o !== e.adr || upg_dat_o !== e.dat) begin
                    miscompares++;
                    $display("[TB] FAIL rom_write: got adr %h dat %h, expected adr %h dat %h",
                             upg_adr_o, upg_dat_o, e.adr, e.dat);
                end
            end
        end
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one 8N1 frame after a one-bit idle gap; returns at the end of
    // the stop bit. bad_stop holds the stop bit low to force a framing error.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_stop);
        @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[7:0], 1'b0);
        applyStimulus(w[15:8], 1'b0);
        applyStimulus(w[23:16], 1'b0);
        applyStimulus(w[31:24], 1'b0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) until the write strobe is visible.
    task automatic waitWrite(input string name);
        int n;
        n = 0;
        while (!upg_wen_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!upg_wen_o) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got no write strobe, expected one within 200 cycles", name);
        end
    endtask

    task automatic pushWrite(input logic [13:0] a, input logic [31:0] d);
        wr_t e;
        e.adr = a;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    // Directed test sequence.
    initial begin
        repeat (4) @(negedge clk);
        checkOutput("reset_wen", {31'd0, upg_wen_o}, 32'd0);
        checkOutput("reset_adr", {18'd0, upg_adr_o}, 32'd0);
        checkOutput("reset_dat", upg_dat_o, 32'd0);
        checkOutput("reset_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_err", {31'd0, err_o}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] normal load");
        pulseStart();
        checkOutput("arm_done", {31'd0, upg_done_o}, 32'd0);
        checkOutput("arm_busy", {31'd0, busy_o}, 32'd1);
        pushWrite(14'd0, 32'h0000_0013);
        pushWrite(14'd1, 32'hDEAD_BEEF);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        sendWord(32'h0000_0013);
        sendWord(32'hDEAD_BEEF);
        waitWrite("normal_last_write");
        @(negedge clk);
        checkOutput("normal_done_t1", {31'd0, upg_done_o}, 32'd0);
        @(negedge clk);
        checkOutput("normal_done_t2", {31'd0, upg_done_o}, 32'd1);
        checkOutput("normal_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("normal_err", {31'd0, err_o}, 32'd0);
        checkOutput("normal_queue", exp_q.size(), 32'd0);

        $display("[TB] zero count");
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("zero_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("zero_err", {31'd0, err_o}, 32'd0);
        checkOutput("zero_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] oversize count");
        pulseStart();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h40, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("oversize_err", {31'd0, err_o}, 32'd1);
        checkOutput("oversize_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("oversize_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] framing error");
        pulseStart();
        checkOutput("rearm_err_cleared", {31'd0, err_o}, 32'd0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h44, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("frame_err", {31'd0, err_o}, 32'd1);
        checkOutput("frame_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("frame_busy", {31'd0, busy_o}, 32'd0);

        $display("[TB] reset mid-load");
        pulseStart();
        pushWrite(14'd0, 32'hA4A3_A2A1);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h00, 1'b0);
        sendWord(32'hA4A3_A2A1);
        applyStimulus(8'hB1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_wen", {31'd0, upg_wen_o}, 32'd0);
        checkOutput("midrst_adr", {18'd0, upg_adr_o}, 32'd0);
        checkOutput("midrst_dat", upg_dat_o, 32'd0);
        checkOutput("midrst_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("midrst_err", {31'd0, err_o}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulseStart();
        pushWrite(14'd0, 32'h1234_5678);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        sendWord(32'h1234_5678);
        waitWrite("after_reset_write");
        repeat (3) @(negedge clk);
        checkOutput("after_reset_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("after_reset_err", {31'd0, err_o}, 32'd0);

        $display("[TB] start during load and glitch");
        pulseStart();
        pushWrite(14'd0, 32'h1234_5678);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h78, 1'b0);
        pulseStart();
        checkOutput("midstart_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("midstart_done", {31'd0, upg_done_o}, 32'd0);
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h12, 1'b0);
        waitWrite("glitch_write");
        repeat (3) @(negedge clk);
        checkOutput("glitch_done", {31'd0, upg_done_o}, 32'd1);
        checkOutput("glitch_err", {31'd0, err_o}, 32'd0);

        repeat (10) @(negedge clk);
        checkOutput("final_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
